// File: rtl/smart_toilet_inlet_seq.sv
// Staggered inlet valve sequencer: OPEN3 -> OPEN2 -> DOSE -> SETTLE (-> FLUSH) -> IDLE.
// Optional flush phase is compiled in with SMART_TOILET_INLET_SEQ_FLUSH_EN.
module smart_toilet_inlet_seq #(
    parameter int CNT_W     = 16,
    parameter int LEAD3     = 400,
    parameter int LEAD2     = 100,
    parameter int SETTLE    = 50,
    parameter int FLUSH_LEN = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] dose_len,
    output logic             valve_soln1,
    output logic             valve_soln2,
    output logic             valve_soln3,
    output logic             flush_valve,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       phase
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPEN3  = 3'd1,
        ST_OPEN2  = 3'd2,
        ST_DOSE   = 3'd3,
        ST_SETTLE = 3'd4
`ifdef SMART_TOILET_INLET_SEQ_FLUSH_EN
        , ST_FLUSH = 3'd5
`endif
    } state_t;

    localparam logic [CNT_W-1:0] L3_LAST = CNT_W'(LEAD3 - 1);
    localparam logic [CNT_W-1:0] L2_LAST = CNT_W'(LEAD2 - 1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Zero-length phases would make the count==N-1 exit unreachable.
    if (LEAD3 < 1 || LEAD2 < 1 || SETTLE < 1 || FLUSH_LEN < 1) begin : g_param_check
        $error("smart_toilet_inlet_seq: phase lengths must be >= 1");
    end

    state_t           state_r;
    state_t           nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] dose_r;
    logic             done_s;
    logic             err_s;

    // Next-state and pulse decode; abort outranks every counter exit.
    always_comb begin
        nxt_s  = state_r;
        done_s = 1'b0;
        err_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            if (start) begin
                if (dose_len == {CNT_W{1'b0}}) begin
                    err_s = 1'b1;
                end else begin
                    nxt_s = ST_OPEN3;
                end
            end else begin
                nxt_s = ST_IDLE;
            end
        end else if (abort) begin
            nxt_s = ST_IDLE;
            err_s = 1'b1;
        end else begin
            case (state_r)
                ST_OPEN3: begin
                    if (cnt_r == L3_LAST) nxt_s = ST_OPEN2;
                    else                  nxt_s = ST_OPEN3;
                end
                ST_OPEN2: begin
                    if (cnt_r == L2_LAST) nxt_s = ST_DOSE;
                    else                  nxt_s = ST_OPEN2;
                end
                ST_DOSE: begin
                    if (cnt_r == dose_r - CNT_W'(1)) nxt_s = ST_SETTLE;
                    else                             nxt_s = ST_DOSE;
                end
                ST_SETTLE: begin
                    if (cnt_r == ST_LAST) begin
`ifdef SMART_TOILET_INLET_SEQ_FLUSH_EN
                        nxt_s = ST_FLUSH;
`else
                        nxt_s  = ST_IDLE;
                        done_s = 1'b1;
`endif
                    end else begin
                        nxt_s = ST_SETTLE;
                    end
                end
`ifdef SMART_TOILET_INLET_SEQ_FLUSH_EN
                ST_FLUSH: begin
                    if (cnt_r == CNT_W'(FLUSH_LEN - 1)) begin
                        nxt_s  = ST_IDLE;
                        done_s = 1'b1;
                    end else begin
                        nxt_s = ST_FLUSH;
                    end
                end
`endif
                default: nxt_s = ST_IDLE;
            endcase
        end
    end

    // State, phase counter, latched dose and registered outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            dose_r      <= {CNT_W{1'b0}};
            valve_soln1 <= 1'b0;
            valve_soln2 <= 1'b0;
            valve_soln3 <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            phase       <= 3'd0;
`ifdef SMART_TOILET_INLET_SEQ_FLUSH_EN
            flush_valve <= 1'b0;
`endif
        end else begin
            state_r <= nxt_s;
            if (nxt_s != state_r || nxt_s == ST_IDLE) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (state_r == ST_IDLE && nxt_s == ST_OPEN3) begin
                dose_r <= dose_len;
            end
            valve_soln3 <= (nxt_s == ST_OPEN3) || (nxt_s == ST_OPEN2) || (nxt_s == ST_DOSE);
            valve_soln2 <= (nxt_s == ST_OPEN2) || (nxt_s == ST_DOSE);
            valve_soln1 <= (nxt_s == ST_DOSE);
            busy        <= (nxt_s != ST_IDLE);
            done        <= done_s;
            err         <= err_s;
            phase       <= nxt_s;
`ifdef SMART_TOILET_INLET_SEQ_FLUSH_EN
            flush_valve <= (nxt_s == ST_FLUSH);
`endif
        end
    end

`ifndef SMART_TOILET_INLET_SEQ_FLUSH_EN
    assign flush_valve = 1'b0;
`endif

endmodule

// File: tb/tb_smart_toilet_inlet_seq.sv
// Self-checking bench for smart_toilet_inlet_seq: directed scenarios plus randomized traffic
// checked against a cycle-offset reference model.
module tb_smart_toilet_inlet_seq;

    localparam int L3 = 4;
    localparam int L2 = 2;
    localparam int ST = 3;
`ifdef SMART_TOILET_INLET_SEQ_FLUSH_EN
    localparam int FL = 2;
`else
    localparam int FL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] dose_len = 16'd0;
    logic        valve_soln1, valve_soln2, valve_soln3, flush_valve;
    logic        busy, done, err;
    logic [2:0]  phase;

    int total = 0;
    int bad   = 0;

    // Reference model: active flag, cycles elapsed since start, latched dose, pulses.
    bit m_active = 1'b0;
    int m_k      = 0;
    int m_dose   = 0;
    bit e_done   = 1'b0;
    bit e_err    = 1'b0;

    smart_toilet_inlet_seq #(
        .CNT_W(16), .LEAD3(L3), .LEAD2(L2), .SETTLE(ST), .FLUSH_LEN(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dose_len(dose_len),
        .valve_soln1(valve_soln1), .valve_soln2(valve_soln2), .valve_soln3(valve_soln3),
        .flush_valve(flush_valve), .busy(busy), .done(done), .err(err), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] dutv();
        return {valve_soln1, valve_soln2, valve_soln3, flush_valve, busy, done, err, phase};
    endfunction

    // Expected outputs from the elapsed-cycle count and the phase boundaries.
    function automatic logic [9:0] expv();
        int b1, b2, b3, b4;
        logic [2:0] ph;
        logic v1, v2, v3, fl;
        b1 = L3;
        b2 = L3 + L2;
        b3 = b2 + m_dose;
        b4 = b3 + ST;
        if (!m_active)    ph = 3'd0;
        else if (m_k <= b1) ph = 3'd1;
        else if (m_k <= b2) ph = 3'd2;
        else if (m_k <= b3) ph = 3'd3;
        else if (m_k <= b4) ph = 3'd4;
        else                ph = 3'd5;
        v3 = (ph >= 3'd1) && (ph <= 3'd3);
        v2 = (ph == 3'd2) || (ph == 3'd3);
        v1 = (ph == 3'd3);
        fl = (ph == 3'd5);
        return {v1, v2, v3, fl, m_active, e_done, e_err, ph};
    endfunction

    task automatic step(input logic s, input logic a, input logic [15:0] d);
        start = s; abort = a; dose_len = d;
        @(posedge clk);
        e_done = 1'b0;
        e_err  = 1'b0;
        if (!m_active) begin
            if (s) begin
                if (d == 16'd0) e_err = 1'b1;
                else begin m_active = 1'b1; m_k = 1; m_dose = int'(d); end
            end
        end else if (a) begin
            m_active = 1'b0; e_err = 1'b1;
        end else begin
            m_k++;
            if (m_k > L3 + L2 + m_dose + ST + FL) begin m_active = 1'b0; e_done = 1'b1; end
        end
        #1;
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (dutv() !== 10'd0) begin
            bad++; $display("FAIL reset got=%b exp=%b", dutv(), 10'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 16'd3);
        total++;
        if (dutv() !== expv()) begin
            bad++; $display("FAIL idle_abort got=%b exp=%b", dutv(), expv());
        end
    endtask

    task automatic test_normal();
        int done_at = -1;
        int v1_cnt = 0;
        step(1'b1, 1'b0, 16'd5);
        for (int c = 1; c <= 16 + FL; c++) begin
            total++;
            if (dutv() !== expv()) begin
                bad++; $display("FAIL normal cyc=%0d got=%b exp=%b", c, dutv(), expv());
            end
            if (done) done_at = c;
            if (valve_soln1) v1_cnt++;
            step(1'b0, 1'b0, 16'd0);
        end
        total++;
        if (done_at !== 15 + FL || v1_cnt !== 5) begin
            bad++; $display("FAIL normal_timing done_at=%0d v1_cycles=%0d exp=%0d/5", done_at, v1_cnt, 15 + FL);
        end
    endtask

    task automatic test_zero_dose();
        step(1'b1, 1'b0, 16'd0);
        total++;
        if (dutv() !== expv() || err !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_dose got=%b exp=%b", dutv(), expv());
        end
        step(1'b0, 1'b0, 16'd0);
        total++;
        if (dutv() !== expv() || err !== 1'b0) begin
            bad++; $display("FAIL zero_dose_pulse got=%b exp=%b", dutv(), expv());
        end
    endtask

    task automatic test_abort();
        step(1'b1, 1'b1, 16'd5);
        for (int c = 1; c <= 9; c++) begin
            total++;
            if (dutv() !== expv()) begin
                bad++; $display("FAIL abort cyc=%0d got=%b exp=%b", c, dutv(), expv());
            end
            step(1'b0, (c == 6), 16'd0);
        end
    endtask

    task automatic test_start_busy();
        int dones = 0;
        step(1'b1, 1'b0, 16'd5);
        for (int c = 1; c <= 18 + FL; c++) begin
            total++;
            if (dutv() !== expv()) begin
                bad++; $display("FAIL start_busy cyc=%0d got=%b exp=%b", c, dutv(), expv());
            end
            if (done) dones++;
            if (c == 8) step(1'b1, 1'b0, 16'd9);
            else        step(1'b0, 1'b0, 16'd9);
        end
        total++;
        if (dones !== 1) begin
            bad++; $display("FAIL start_busy_done_count got=%0d exp=1", dones);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 16'd5);
        for (int c = 1; c < 8; c++) step(1'b0, 1'b0, 16'd0);
        total++;
        if (valve_soln1 !== 1'b1) begin
            bad++; $display("FAIL pre_reset_dose got=%b exp=1", valve_soln1);
        end
        #2 rst = 1'b1;
        #1;
        m_active = 1'b0; e_done = 1'b0; e_err = 1'b0;
        total++;
        if (dutv() !== 10'd0) begin
            bad++; $display("FAIL async_reset got=%b exp=%b", dutv(), 10'd0);
        end
        #1 rst = 1'b0;
        step(1'b0, 1'b0, 16'd0);
        total++;
        if (dutv() !== expv()) begin
            bad++; $display("FAIL post_reset got=%b exp=%b", dutv(), expv());
        end
        test_normal();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                 16'($urandom_range(0, 6)));
            total++;
            if (dutv() !== expv()) begin
                bad++; $display("FAIL random cyc=%0d got=%b exp=%b", c, dutv(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero_dose();
        test_abort();
        test_start_busy();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
